// File: rtl/lpddr2_port_arbiter_pkg.sv
// Shared types for the LPDDR2 port arbiter: FSM state encoding and the
// read-data word returned on a timed-out transaction.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/lpddr2_port_arbiter_rr.sv
// Combinational round-robin picker: the first requester strictly after the
// last grant wins, wrapping at NUM_PORTS.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  logic [IDX_W-1:0] cand_s;

  // scan from last+1 around to last itself, keep the first hit
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_s = IDX_W'((int'(last) + i) % NUM_PORTS);
      if (!any && req[cand_s]) begin
        any           = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = cand_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/lpddr2_port_arbiter.sv
// Round-robin multi-port front end onto one LPDDR2 request interface, one
// transaction in flight. Define ARB_TIMEOUT_EN to bound the WAIT state.
module lpddr2_port_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 27,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]        port_done,
  output logic [DATA_W-1:0]           port_rdata,
  output logic [NUM_PORTS-1:0]        port_err,
  output logic [ADDR_W-1:0]           lpddr2_address,
  output logic [DATA_W-1:0]           lpddr2_write_data,
  output logic                        lpddr2_rreq,
  output logic                        lpddr2_wreq,
  input  logic                        lpddr2_busy,
  input  logic                        lpddr2_ack,
  input  logic [DATA_W-1:0]           lpddr2_read_data
);

  localparam int IW = $clog2(NUM_PORTS);

  arb_state_e           state_r;
  arb_state_e           state_nx_s;
  logic [IW-1:0]        rr_ptr_r;
  logic [IW-1:0]        gidx_r;
  logic [IW-1:0]        sel_idx_s;
  logic [NUM_PORTS-1:0] sel_grant_s;
  logic                 sel_any_s;
  logic                 we_r;
  logic                 timeout_s;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IW)
  ) u_rr (
    .req   (port_req),
    .last  (rr_ptr_r),
    .grant (sel_grant_s),
    .idx   (sel_idx_s),
    .any   (sel_any_s)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_r;

  // counts WAIT cycles; cleared whenever the FSM is elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (state_r == WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == WAIT) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // next state and the request strobes, which must see busy in the same cycle
  always_comb begin
    state_nx_s  = state_r;
    lpddr2_rreq = 1'b0;
    lpddr2_wreq = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_any_s) state_nx_s = ISSUE;
        else           state_nx_s = IDLE;
      end
      ISSUE: begin
        if (!lpddr2_busy) begin
          state_nx_s  = WAIT;
          lpddr2_rreq = !we_r;
          lpddr2_wreq = we_r;
        end else begin
          state_nx_s  = ISSUE;
        end
      end
      WAIT: begin
        if (lpddr2_ack || timeout_s) state_nx_s = RESP;
        else                         state_nx_s = WAIT;
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // state, grant latch and registered completion outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      rr_ptr_r          <= IW'(NUM_PORTS - 1);
      gidx_r            <= '0;
      we_r              <= 1'b0;
      lpddr2_address    <= '0;
      lpddr2_write_data <= '0;
      port_done         <= '0;
      port_rdata        <= '0;
      port_err          <= '0;
    end else begin
      state_r    <= state_nx_s;
      port_done  <= '0;
      port_err   <= '0;
      port_rdata <= '0;
      if (state_r == IDLE && sel_any_s) begin
        gidx_r            <= sel_idx_s;
        rr_ptr_r          <= sel_idx_s;
        we_r              <= |(port_we & sel_grant_s);
        lpddr2_address    <= port_addr[sel_idx_s*ADDR_W +: ADDR_W];
        lpddr2_write_data <= port_wdata[sel_idx_s*DATA_W +: DATA_W];
      end
      // completion is loaded on the WAIT exit edge so it is visible during RESP
      if (state_r == WAIT && lpddr2_ack) begin
        port_done[gidx_r] <= 1'b1;
        port_rdata        <= we_r ? '0 : lpddr2_read_data;
      end else if (state_r == WAIT && timeout_s) begin
        port_done[gidx_r] <= 1'b1;
        port_err[gidx_r]  <= 1'b1;
        port_rdata        <= DATA_W'(ARB_ERR_DATA);
      end
    end
  end

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Self-checking bench for lpddr2_port_arbiter (4 ports); a scoreboard queue of
// expected completions is checked by a monitor, the timeout case needs ARB_TIMEOUT_EN.
module tb_lpddr2_port_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 27;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    port_req;
  logic [NP-1:0]    port_we;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_wdata;
  logic [NP-1:0]    port_done;
  logic [DW-1:0]    port_rdata;
  logic [NP-1:0]    port_err;
  logic [AW-1:0]    lpddr2_address;
  logic [DW-1:0]    lpddr2_write_data;
  logic             lpddr2_rreq;
  logic             lpddr2_wreq;
  logic             lpddr2_busy;
  logic             lpddr2_ack = 1'b0;
  logic [DW-1:0]    lpddr2_read_data = '0;

  typedef struct {
    logic [NP-1:0] done;
    logic [DW-1:0] rdata;
    logic [NP-1:0] err;
  } exp_t;

  exp_t    sb[$];
  exp_t    mon_e;
  int      vectors = 0;
  int      miscompares = 0;
  logic [DW-1:0] resp_base = '0;
  int      resp_delay = 1;
  int      resp_cnt = 0;
  bit      resp_pend = 1'b0;

  always #5 clk = ~clk;

  lpddr2_port_arbiter #(
    .NUM_PORTS      (NP),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .port_req          (port_req),
    .port_we           (port_we),
    .port_addr         (port_addr),
    .port_wdata        (port_wdata),
    .port_done         (port_done),
    .port_rdata        (port_rdata),
    .port_err          (port_err),
    .lpddr2_address    (lpddr2_address),
    .lpddr2_write_data (lpddr2_write_data),
    .lpddr2_rreq       (lpddr2_rreq),
    .lpddr2_wreq       (lpddr2_wreq),
    .lpddr2_busy       (lpddr2_busy),
    .lpddr2_ack        (lpddr2_ack),
    .lpddr2_read_data  (lpddr2_read_data)
  );

  // controller model: ack resp_delay cycles after a request strobe, data = base ^ addr
  always @(negedge clk) begin
    lpddr2_ack = 1'b0;
    if (rst) begin
      resp_pend = 1'b0;
    end else begin
      if (resp_pend) begin
        if (resp_cnt == 0) begin
          lpddr2_ack       = 1'b1;
          lpddr2_read_data = resp_base ^ DW'(lpddr2_address);
          resp_pend        = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
      if (lpddr2_rreq || lpddr2_wreq) begin
        resp_pend = 1'b1;
        resp_cnt  = resp_delay - 1;
      end
    end
  end

  // completion monitor against the scoreboard
  always @(negedge clk) begin
    if (!rst && port_done !== '0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done=%b rdata=%h err=%b, required no completion",
                 port_done, port_rdata, port_err);
      end else begin
        mon_e = sb.pop_front();
        if (port_done !== mon_e.done || port_rdata !== mon_e.rdata || port_err !== mon_e.err) begin
          miscompares++;
          $display("FAIL completion: got done=%b rdata=%h err=%b, required done=%b rdata=%h err=%b",
                   port_done, port_rdata, port_err, mon_e.done, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  task automatic request(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    port_we[p]               = we;
    port_addr[p*AW +: AW]    = a;
    port_wdata[p*DW +: DW]   = wd;
    port_req[p]              = 1'b1;
  endtask

  // run until the scoreboard empties, dropping each port's request on its done
  task automatic drain(input int budget, input logic [NP-1:0] keep);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      port_req = port_req & ~(port_done & ~keep);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    port_req = '0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d completions outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    port_req = '0; port_we = '0; port_addr = '0; port_wdata = '0; lpddr2_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({port_done, port_err, lpddr2_rreq, lpddr2_wreq} !== '0 || port_rdata !== '0 ||
        lpddr2_address !== '0 || lpddr2_write_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got done=%b err=%b rreq=%b wreq=%b addr=%h, required all 0",
               port_done, port_err, lpddr2_rreq, lpddr2_wreq, lpddr2_address);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    resp_base  = 32'h1234_5678 ^ 32'h0000_0010;
    resp_delay = 1;
    @(posedge clk); #1;
    request(0, 1'b0, 27'h10, '0);
    sb.push_back('{4'b0001, 32'h1234_5678, 4'b0000});
    @(negedge clk);
    vectors++;
    if (lpddr2_rreq !== 1'b0) begin
      miscompares++; $display("FAIL rreq_cycle0: got %b, required 0", lpddr2_rreq);
    end
    @(negedge clk);
    vectors++;
    if (lpddr2_rreq !== 1'b1 || lpddr2_wreq !== 1'b0 || lpddr2_address !== 27'h10) begin
      miscompares++;
      $display("FAIL rreq_cycle1: got rreq=%b wreq=%b addr=%h, required 1 0 010", lpddr2_rreq, lpddr2_wreq, lpddr2_address);
    end
    @(negedge clk);
    vectors++;
    if (lpddr2_rreq !== 1'b0 || port_done !== '0) begin
      miscompares++; $display("FAIL cycle2: got rreq=%b done=%b, required 0 0000", lpddr2_rreq, port_done);
    end
    @(negedge clk);
    vectors++;
    if (port_done !== 4'b0001) begin
      miscompares++; $display("FAIL done_latency: got %b at cycle 3, required 0001", port_done);
    end
    port_req[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_busy();
    int wpulses = 0;
    resp_delay  = 2;
    lpddr2_busy = 1'b1;
    request(1, 1'b1, 27'h2_0040, 32'hCAFE_F00D);
    sb.push_back('{4'b0010, 32'h0, 4'b0000});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (lpddr2_wreq === 1'b1 || lpddr2_rreq === 1'b1) wpulses++;
    end
    vectors++;
    if (wpulses != 0 || lpddr2_write_data !== 32'hCAFE_F00D || lpddr2_address !== 27'h2_0040) begin
      miscompares++;
      $display("FAIL write_busy_hold: got %0d strobes wdata=%h addr=%h, required 0 cafef00d 0020040",
               wpulses, lpddr2_write_data, lpddr2_address);
    end
    @(posedge clk); #1;
    lpddr2_busy = 1'b0;
    @(negedge clk);
    vectors++;
    if (lpddr2_wreq !== 1'b1 || lpddr2_rreq !== 1'b0) begin
      miscompares++; $display("FAIL wreq_after_busy: got wreq=%b rreq=%b, required 1 0", lpddr2_wreq, lpddr2_rreq);
    end
    @(negedge clk);
    vectors++;
    if (lpddr2_wreq !== 1'b0) begin
      miscompares++; $display("FAIL wreq_single: got %b, required 0", lpddr2_wreq);
    end
    drain(20, '0);
  endtask

  task automatic test_round_robin();
    resp_base  = 32'h0BAD_0000;
    resp_delay = 1;
    @(posedge clk); #1;
    request(0, 1'b0, 27'h100, '0);
    request(1, 1'b0, 27'h200, '0);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{4'b0001, 32'h0BAD_0100, 4'b0000});
      sb.push_back('{4'b0010, 32'h0BAD_0200, 4'b0000});
    end
    drain(100, 4'b0011);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int seen = 0;
    resp_delay = 6;
    request(2, 1'b0, 27'h300, '0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({port_done, port_err, lpddr2_rreq, lpddr2_wreq} !== '0 || lpddr2_address !== '0) begin
      miscompares++;
      $display("FAIL reset_abort: got done=%b rreq=%b addr=%h, required 0 0 0", port_done, lpddr2_rreq, lpddr2_address);
    end
    port_req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (port_done !== '0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL abort_no_done: got %0d done pulses, required 0", seen);
    end
    resp_delay = 1;
    @(posedge clk); #1;
    request(3, 1'b0, 27'h3F0, '0);
    request(0, 1'b0, 27'h0F0, '0);
    sb.push_back('{4'b0001, resp_base ^ 32'h0F0, 4'b0000});
    sb.push_back('{4'b1000, resp_base ^ 32'h3F0, 4'b0000});
    drain(60, '0);
  endtask

  task automatic test_four_port_rr();
    resp_base = 32'h5A5A_0000;
    request(3, 1'b0, 27'h7_7777, '0);
    sb.push_back('{4'b1000, 32'h5A5A_0000 ^ 32'h7_7777, 4'b0000});
    drain(30, '0);
    request(1, 1'b0, 27'h11, '0);
    request(2, 1'b1, 27'h22, 32'h0000_2222);
    sb.push_back('{4'b0010, 32'h5A5A_0011, 4'b0000});
    sb.push_back('{4'b0100, 32'h0, 4'b0000});
    drain(60, '0);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    resp_delay = 12;
    request(0, 1'b0, 27'h44, '0);
    sb.push_back('{4'b0001, 32'hDEAD_BEEF, 4'b0001});
    drain(40, '0);
    repeat (12) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write_busy();
    test_round_robin();
    test_reset_in_wait();
    test_four_port_rr();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

endmodule
